gate_alu_pipe: RTL and testbench



---
 rtl/gate_alu_pkg.sv | 23 ++
 rtl/gate_alu_skid.sv | 84 ++++++++
 rtl/gate_alu_pipe.sv | 83 ++++++++
 tb/tb_gate_alu_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_alu_pkg.sv
// Shared constants for gate_alu_pipe: operation codes, skid buffer states, flag width.
// The accumulator codes are only functional when GATE_ALU_ACC_EN is defined.
package gate_alu_pkg;

   localparam logic [2:0] OP_AND      = 3'd0;
   localparam logic [2:0] OP_OR       = 3'd1;
   localparam logic [2:0] OP_XOR      = 3'd2;
   localparam logic [2:0] OP_NAND     = 3'd3;
   localparam logic [2:0] OP_NOR      = 3'd4;
   localparam logic [2:0] OP_XNOR     = 3'd5;
   localparam logic [2:0] OP_ACC_AND  = 3'd6;
   localparam logic [2:0] OP_ACC_LOAD = 3'd7;

   // Result is carried with {out_zero, out_ones} above it.
   localparam int FLAG_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

endpackage

// File: rtl/gate_alu_skid.sv
// Two-entry valid/ready skid buffer with a registered in_ready.
// The output register resets to RESET_VAL; the skid register is not reset.
module gate_alu_skid
   import gate_alu_pkg::*;
#(
   parameter int                DATA_W    = 10,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   buf_state_e        state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic              push, pop;

   assign push = in_valid && in_ready_q;
   assign pop  = out_ready && (state_q != ST_EMPTY);

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      skid_data_d = skid_data_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               out_data_d = in_data;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               out_data_d = in_data;
            end else if (push) begin
               skid_data_d = in_data;
               state_d     = ST_TWO;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               out_data_d = skid_data_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Registered ready: derived from the next state, never from out_ready directly.
      in_ready_d = (state_d != ST_TWO);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         out_data_q <= RESET_VAL;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         in_ready_q <= in_ready_d;
      end
   end

   // NOTE: skid data needs no reset; its validity is tracked entirely by state_q.
   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = out_data_q;

endmodule

// File: rtl/gate_alu_pipe.sv
// Registered bitwise ALU with zero/ones flags behind a two-entry skid buffer.
// Define GATE_ALU_ACC_EN to build the accumulator used by ACC_AND / ACC_LOAD.
module gate_alu_pipe
   import gate_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero,
   output logic             out_ones
);

   localparam int PAY_W = WIDTH + FLAG_W;

   logic             accept;
   logic [WIDTH-1:0] result;
   logic [PAY_W-1:0] in_payload;
   logic [PAY_W-1:0] out_payload;

   assign accept = in_valid && in_ready;

`ifdef GATE_ALU_ACC_EN
   logic [WIDTH-1:0] acc_q, acc_d;
`endif

   always_comb begin
      result = '0;
      case (op)
         OP_AND:      result = in1 & in2;
         OP_OR:       result = in1 | in2;
         OP_XOR:      result = in1 ^ in2;
         OP_NAND:     result = ~(in1 & in2);
         OP_NOR:      result = ~(in1 | in2);
         OP_XNOR:     result = ~(in1 ^ in2);
`ifdef GATE_ALU_ACC_EN
         OP_ACC_AND:  result = acc_q & in1;
         OP_ACC_LOAD: result = in1;
`endif
         default:     result = '0;
      endcase
   end

`ifdef GATE_ALU_ACC_EN
   // Both accumulator codes leave acc equal to the result they emit.
   always_comb begin
      acc_d = acc_q;
      if (accept && (op == OP_ACC_AND || op == OP_ACC_LOAD)) acc_d = result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '1;
      else        acc_q <= acc_d;
   end
`endif

   assign in_payload = {~|result, &result, result};

   gate_alu_skid #(
      .DATA_W   (PAY_W),
      .RESET_VAL({1'b1, 1'b0, {WIDTH{1'b0}}})
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_payload)
   );

   assign {out_zero, out_ones, out} = out_payload;

endmodule

// File: tb/tb_gate_alu_pipe.sv
// Self-checking bench for gate_alu_pipe; expected beats come from a queue model of a 2-deep FIFO.
module tb_gate_alu_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         out_zero;
   logic         out_ones;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic         zero;
      logic         ones;
      logic [W-1:0] res;
   } beat_t;

   beat_t        model_q[$];
   logic [W-1:0] model_acc;

   always #5 clk = ~clk;

   gate_alu_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in1      (in1),
      .in2      (in2),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .out_zero (out_zero),
      .out_ones (out_ones)
   );

   function automatic logic [W-1:0] gate_fn(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      case (o)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      model_q.delete();
      model_acc = '1;
   endtask

   task automatic model_accept(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      beat_t        bt;
      if (o < 3'd6) begin
         r = gate_fn(o, a, b);
      end else begin
`ifdef GATE_ALU_ACC_EN
         if (o == 3'd7) model_acc = a;
         else           model_acc = model_acc & a;
         r = model_acc;
`else
         r = '0;
`endif
      end
      bt.res  = r;
      bt.zero = (r == 0);
      bt.ones = (r == '1);
      model_q.push_back(bt);
   endtask

   // Drives one cycle from the negedge, updates the model at the posedge, returns at the next negedge.
   task automatic advance(input logic v, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic r, output logic accepted);
      logic pop_pred;
      in_valid  = v;
      op        = o;
      in1       = a;
      in2       = b;
      out_ready = r;
      accepted  = v && (model_q.size() < 2);
      pop_pred  = r && (model_q.size() > 0);
      @(posedge clk);
      if (pop_pred) void'(model_q.pop_front());
      if (accepted) model_accept(o, a, b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [11:0] got;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
      model_reset();
      repeat (2) @(negedge clk);
      got = {out_valid, in_ready, out_zero, out_ones, out};
      checks++;
      if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", got, {1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      end
      rst_n = 1'b1;
      @(negedge clk);
      got = {out_valid, in_ready, out_zero, out_ones, out};
      checks++;
      if (got !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_release: got %h expected %h", got, {1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      end
   endtask

   task automatic test_ops();
      logic [W-1:0] exp_tab [6];
      logic         a;
      exp_tab = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99};
      for (int i = 0; i < 6; i++) begin
         advance(1'b1, 3'(i), 8'hCC, 8'hAA, 1'b1, a);
         checks++;
         if ({out_valid, out} !== {1'b1, exp_tab[i]}) begin
            failures++;
            $display("FAIL op%0d: got valid=%b out=%h expected valid=1 out=%h", i, out_valid, out, exp_tab[i]);
         end
      end
      advance(1'b0, 3'd0, '0, '0, 1'b1, a);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ops_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_flags();
      logic a;
      advance(1'b1, 3'd0, 8'h0F, 8'hF0, 1'b1, a);
      checks++;
      if ({out_zero, out_ones, out} !== {1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL flag_zero: got z=%b o=%b out=%h expected z=1 o=0 out=00", out_zero, out_ones, out);
      end
      advance(1'b1, 3'd5, 8'h5A, 8'h5A, 1'b1, a);
      checks++;
      if ({out_zero, out_ones, out} !== {1'b0, 1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL flag_ones: got z=%b o=%b out=%h expected z=0 o=1 out=FF", out_zero, out_ones, out);
      end
      advance(1'b0, 3'd0, '0, '0, 1'b1, a);
   endtask

   task automatic test_backpressure();
      logic  a;
      int    n;
      beat_t exp_b;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== (model_q.size() < 2)) begin
            failures++;
            $display("FAIL bp_ready_%0d: got %b expected %b", i, in_ready, model_q.size() < 2);
         end
         advance(1'b1, 3'($urandom_range(0, 5)), W'($urandom), W'($urandom), 1'b0, a);
      end
      checks++;
      if ({in_ready, out_valid} !== 2'b01) begin
         failures++;
         $display("FAIL bp_full: got ready=%b valid=%b expected ready=0 valid=1", in_ready, out_valid);
      end
      n = 0;
      while (model_q.size() > 0 && n < 10) begin
         exp_b = model_q[0];
         checks++;
         if ({out_valid, out_zero, out_ones, out} !== {1'b1, exp_b}) begin
            failures++;
            $display("FAIL bp_drain_%0d: got %h expected %h", n, {out_valid, out_zero, out_ones, out}, {1'b1, exp_b});
         end
         advance(1'b0, 3'd0, '0, '0, 1'b1, a);
         n++;
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01 || n != 2) begin
         failures++;
         $display("FAIL bp_empty: got valid=%b ready=%b beats=%0d expected valid=0 ready=1 beats=2", out_valid, in_ready, n);
      end
   endtask

   task automatic test_acc();
      logic [2:0]   ops  [3];
      logic [W-1:0] vals [3];
      logic [W-1:0] exp_tab [3];
      logic         a;
      ops  = '{3'd7, 3'd6, 3'd6};
      vals = '{8'hF3, 8'h3F, 8'h1C};
`ifdef GATE_ALU_ACC_EN
      exp_tab = '{8'hF3, 8'h33, 8'h10};
`else
      exp_tab = '{8'h00, 8'h00, 8'h00};
`endif
      for (int i = 0; i < 3; i++) begin
         advance(1'b1, ops[i], vals[i], W'($urandom), 1'b1, a);
         checks++;
         if ({out_valid, out_zero, out} !== {1'b1, exp_tab[i] == 0, exp_tab[i]}) begin
            failures++;
            $display("FAIL acc_%0d: got valid=%b z=%b out=%h expected out=%h", i, out_valid, out_zero, out, exp_tab[i]);
         end
      end
      advance(1'b0, 3'd0, '0, '0, 1'b1, a);
   endtask

   task automatic test_reset_mid_stall();
      logic         a;
      logic [W-1:0] exp_r;
      advance(1'b1, 3'd1, 8'h12, 8'h34, 1'b0, a);
      advance(1'b1, 3'd2, 8'h56, 8'h78, 1'b0, a);
      checks++;
      if ({in_ready, out_valid} !== 2'b01) begin
         failures++;
         $display("FAIL stall_two: got ready=%b valid=%b expected ready=0 valid=1", in_ready, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_zero, out_ones, out} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL async_reset: got %h expected %h", {out_valid, in_ready, out_zero, out_ones, out},
                  {1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
`ifdef GATE_ALU_ACC_EN
      exp_r = 8'hA5;
`else
      exp_r = 8'h00;
`endif
      advance(1'b1, 3'd6, 8'hA5, W'($urandom), 1'b1, a);
      checks++;
      if ({out_valid, out} !== {1'b1, exp_r}) begin
         failures++;
         $display("FAIL post_reset_acc: got valid=%b out=%h expected valid=1 out=%h", out_valid, out, exp_r);
      end
      advance(1'b0, 3'd0, '0, '0, 1'b1, a);
   endtask

   task automatic test_throughput();
      int           sent, got, cyc;
      logic [2:0]   o;
      logic [W-1:0] a, b;
      logic         r, accd;
      beat_t        exp_b;
      sent = 0; got = 0; cyc = 0;
      o = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
      while ((sent < 100 || model_q.size() > 0) && cyc < 2000) begin
         checks++;
         if ({in_ready, out_valid} !== {model_q.size() < 2, model_q.size() > 0}) begin
            failures++;
            $display("FAIL tp_hs_cyc%0d: got ready=%b valid=%b expected ready=%b valid=%b", cyc, in_ready, out_valid,
                     model_q.size() < 2, model_q.size() > 0);
         end
         if (model_q.size() > 0) begin
            exp_b = model_q[0];
            checks++;
            if ({out_zero, out_ones, out} !== exp_b) begin
               failures++;
               $display("FAIL tp_beat%0d: got %h expected %h", got, {out_zero, out_ones, out}, exp_b);
            end
         end
         r = 1'($urandom_range(0, 1));
         if (r && model_q.size() > 0) got++;
         advance(sent < 100, o, a, b, r, accd);
         if (accd) begin
            sent++;
            o = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
         end
         cyc++;
      end
      checks++;
      if (cyc >= 2000 || got != 100) begin
         failures++;
         $display("FAIL tp_count: got %0d beats in %0d cycles expected 100 beats", got, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_flags();
      test_backpressure();
      test_acc();
      test_reset_mid_stall();
      test_throughput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
